// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, redirect kind codes and default widths.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } pc_state_e;

    localparam logic [1:0] RK_BRANCH = 2'b00;
    localparam logic [1:0] RK_JUMP   = 2'b01;
    localparam logic [1:0] RK_CALL   = 2'b10;
    localparam logic [1:0] RK_RET    = 2'b11;

    localparam int DEFAULT_PC_WIDTH    = 10;
    localparam int DEFAULT_INSTR_WIDTH = 32;
    localparam int DEFAULT_STACK_DEPTH = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of the sequencer's memory-side, decode-side and control signals, plus the FSM debug view.
interface pc_sequencer_if #(
    parameter int PC_WIDTH    = pc_seq_pkg::DEFAULT_PC_WIDTH,
    parameter int INSTR_WIDTH = pc_seq_pkg::DEFAULT_INSTR_WIDTH
) ();

    // Handshakes: imemReq is held with a stable imemAddr until the cycle imemAck is high (ack may
    // coincide with the first request cycle); instrValid holds instr/instrPc stable until the cycle
    // instrReady is high, and redirect/halt inputs only matter in that same accepting cycle.
    logic                   imemReq;
    logic [PC_WIDTH-1:0]    imemAddr;
    logic                   imemAck;
    logic [INSTR_WIDTH-1:0] imemData;

    logic                   instrValid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    instrPc;
    logic                   instrReady;

    logic                   redirectValid;
    logic [1:0]             redirectKind;
    logic [PC_WIDTH-1:0]    redirectTarget;

    logic                   haltReq;
    logic                   resumeReq;
    logic [PC_WIDTH-1:0]    programCounter;
    logic                   halted;
    logic                   stackFault;
    pc_seq_pkg::pc_state_e  dbgState;

    modport master (
        output imemReq, imemAddr,
        input  imemAck, imemData,
        output instrValid, instr, instrPc,
        input  instrReady, redirectValid, redirectKind, redirectTarget,
        input  haltReq, resumeReq,
        output programCounter, halted, stackFault, dbgState
    );

    modport slave (
        input  imemReq, imemAddr,
        output imemAck, imemData,
        input  instrValid, instr, instrPc,
        output instrReady, redirectValid, redirectKind, redirectTarget,
        output haltReq, resumeReq,
        input  programCounter, halted, stackFault, dbgState
    );

endinterface

// File: rtl/pc_sequencer_return_stack.sv
// LIFO of return addresses; pushes when full and pops when empty are dropped (caller flags the fault).
module return_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    wr_idx, top_idx;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign wr_idx  = IW'(count_q);
    assign top_idx = IW'(count_q - CW'(1));
    assign top_o   = mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        if (push_i && !full_o) begin
            count_d = count_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entries need no reset: only the count decides what is visible.
    always_ff @(posedge clock) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC owner: fetches a word, holds it for decode, then applies redirects and halt/resume.
// Call/return via a return stack is built only when PC_RETURN_STACK_EN is defined.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                  PC_WIDTH     = DEFAULT_PC_WIDTH,
    parameter int                  INSTR_WIDTH  = DEFAULT_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  STACK_DEPTH  = DEFAULT_STACK_DEPTH
) (
    input  logic           clock,
    input  logic           resetN,
    pc_sequencer_if.master bus
);

    pc_state_e              state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;
    logic [PC_WIDTH-1:0]    pc_seq;

    if (STACK_DEPTH < 1) begin : g_depth_check
        $error("STACK_DEPTH must be at least 1");
    end

    // Wrap-around at the top of the address space falls out of the PC_WIDTH-bit adds.
    assign pc_seq = instr_pc_q + PC_WIDTH'(1);

`ifdef PC_RETURN_STACK_EN
    logic                push, pop, fault_set;
    logic                stk_full, stk_empty;
    logic [PC_WIDTH-1:0] stk_top;
    logic                fault_q;

    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clock   (clock),
        .resetN  (resetN),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_seq),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_ff @(posedge clock) begin
        if (!resetN) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.stackFault = fault_q;
`else
    assign bus.stackFault = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
`ifdef PC_RETURN_STACK_EN
        push       = 1'b0;
        pop        = 1'b0;
        fault_set  = 1'b0;
`endif
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (bus.imemAck) begin
                    instr_d    = bus.imemData;
                    instr_pc_d = pc_q;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.instrReady) begin
                    pc_d = pc_seq;
                    if (bus.redirectValid) begin
                        case (bus.redirectKind)
                            RK_BRANCH: pc_d = pc_seq + bus.redirectTarget;
                            RK_JUMP:   pc_d = bus.redirectTarget;
                            RK_CALL: begin
                                pc_d = bus.redirectTarget;
`ifdef PC_RETURN_STACK_EN
                                if (stk_full) fault_set = 1'b1;
                                else          push      = 1'b1;
`endif
                            end
                            RK_RET: begin
`ifdef PC_RETURN_STACK_EN
                                if (stk_empty) begin
                                    fault_set = 1'b1;
                                end else begin
                                    pop  = 1'b1;
                                    pc_d = stk_top;
                                end
`endif
                            end
                        endcase
                    end
                    state_d = bus.haltReq ? HALTED : FETCH;
                end
            end
            HALTED: begin
                if (bus.resumeReq) begin
                    state_d = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign bus.imemReq        = (state_q == FETCH);
    assign bus.imemAddr       = pc_q;
    assign bus.instrValid     = (state_q == ISSUE);
    assign bus.instr          = instr_q;
    assign bus.instrPc        = instr_pc_q;
    assign bus.programCounter = pc_q;
    assign bus.halted         = (state_q == HALTED);
    assign bus.dbgState       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a transaction-level model.
// Expectations for call/return follow PC_RETURN_STACK_EN, matching the build of the design.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int PCW   = 10;
    localparam int IW    = 32;
    localparam int PCM   = 1024;
    localparam int DEPTH = 4;

    logic clock;
    logic resetN;

    pc_sequencer_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW)) bus ();

    pc_sequencer #(
        .PC_WIDTH     (PCW),
        .INSTR_WIDTH  (IW),
        .RESET_VECTOR (10'h000),
        .STACK_DEPTH  (DEPTH)
    ) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks;
    int errors;

    // Reference model: what the sequencer is doing and what it must show.
    bit          m_boot, m_req, m_valid, m_halt, m_fault;
    int          m_pc, m_ipc;
    logic [31:0] m_instr;
    int          ret_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.imemAck        = 1'b0;
        bus.imemData       = '0;
        bus.instrReady     = 1'b0;
        bus.redirectValid  = 1'b0;
        bus.redirectKind   = 2'b00;
        bus.redirectTarget = '0;
        bus.haltReq        = 1'b0;
        bus.resumeReq      = 1'b0;
    endtask

    // Reset with a pending ack and random decode-side noise; everything must come back clean.
    task automatic do_reset();
        resetN             = 1'b0;
        bus.imemAck        = 1'b1;
        bus.imemData       = $urandom();
        bus.instrReady     = 1'($urandom_range(0, 1));
        bus.redirectValid  = 1'($urandom_range(0, 1));
        bus.haltReq        = 1'($urandom_range(0, 1));
        bus.resumeReq      = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
        check_eq("rst_req",    32'(bus.imemReq),        32'd0);
        check_eq("rst_valid",  32'(bus.instrValid),     32'd0);
        check_eq("rst_halted", 32'(bus.halted),         32'd0);
        check_eq("rst_pc",     32'(bus.programCounter), 32'd0);
        check_eq("rst_instr",  bus.instr,               32'd0);
        check_eq("rst_ipc",    32'(bus.instrPc),        32'd0);
        check_eq("rst_fault",  32'(bus.stackFault),     32'd0);
        resetN  = 1'b1;
        set_idle();
        m_boot  = 1'b1;
        m_req   = 1'b0;
        m_valid = 1'b0;
        m_halt  = 1'b0;
        m_fault = 1'b0;
        m_pc    = 0;
        m_ipc   = 0;
        m_instr = '0;
        ret_q.delete();
    endtask

    function automatic int next_pc(input bit rv, input logic [1:0] rk, input logic [9:0] rt);
        int off;
        int nxt;
        nxt = (m_ipc + 1) % PCM;
        if (rv) begin
            case (rk)
                2'b00: begin
                    off = int'(rt);
                    if (off >= PCM / 2) off = off - PCM;
                    nxt = (m_ipc + 1 + off + PCM) % PCM;
                end
                2'b01: nxt = int'(rt);
                2'b10: begin
`ifdef PC_RETURN_STACK_EN
                    if (ret_q.size() < DEPTH) ret_q.push_back((m_ipc + 1) % PCM);
                    else                      m_fault = 1'b1;
`endif
                    nxt = int'(rt);
                end
                default: begin
`ifdef PC_RETURN_STACK_EN
                    if (ret_q.size() > 0) nxt = ret_q.pop_back();
                    else                  m_fault = 1'b1;
`endif
                end
            endcase
        end
        return nxt;
    endfunction

    // Compare what is visible now, apply one cycle of inputs, advance the model, step a clock.
    task automatic cycle(input bit ack, input logic [31:0] data, input bit ready, input bit rv,
                         input logic [1:0] rk, input logic [9:0] rt, input bit hr, input bit rs);
        check_eq("imemReq",    32'(bus.imemReq),        32'(m_req));
        check_eq("instrValid", 32'(bus.instrValid),     32'(m_valid));
        check_eq("halted",     32'(bus.halted),         32'(m_halt));
        check_eq("pc",         32'(bus.programCounter), 32'(m_pc));
        check_eq("stackFault", 32'(bus.stackFault),     32'(m_fault));
        if (m_req) check_eq("imemAddr", 32'(bus.imemAddr), 32'(m_pc));
        if (m_valid) begin
            check_eq("instr",   bus.instr,         m_instr);
            check_eq("instrPc", 32'(bus.instrPc),  32'(m_ipc));
        end
        bus.imemAck        = ack;
        bus.imemData       = data;
        bus.instrReady     = ready;
        bus.redirectValid  = rv;
        bus.redirectKind   = rk;
        bus.redirectTarget = rt;
        bus.haltReq        = hr;
        bus.resumeReq      = rs;
        if (m_boot) begin
            m_boot = 1'b0;
            m_req  = 1'b1;
        end else if (m_req) begin
            if (ack) begin
                m_instr = data;
                m_ipc   = m_pc;
                m_req   = 1'b0;
                m_valid = 1'b1;
            end
        end else if (m_valid) begin
            if (ready) begin
                m_pc    = next_pc(rv, rk, rt);
                m_valid = 1'b0;
                if (hr) m_halt = 1'b1;
                else    m_req  = 1'b1;
            end
        end else if (m_halt) begin
            if (rs) begin
                m_halt = 1'b0;
                m_req  = 1'b1;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic cycle_idle();
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 10'd0, 1'b0, 1'b0);
    endtask

    // One instruction from a fetching state: ack after ack_dly, accept after rdy_dly noisy cycles.
    task automatic run_instr(input int ack_dly, input int rdy_dly, input logic [31:0] data,
                             input bit rv, input logic [1:0] rk, input logic [9:0] rt, input bit hr);
        for (int i = 0; i < ack_dly; i++) cycle_idle();
        cycle(1'b1, data, 1'b0, 1'b0, 2'b00, 10'd0, 1'b0, 1'b0);
        for (int i = 0; i < rdy_dly; i++)
            cycle(1'($urandom_range(0, 1)), $urandom(), 1'b0, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 10'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
        cycle(1'b0, 32'd0, 1'b1, rv, rk, rt, hr, 1'b0);
    endtask

    task automatic goto_pc(input logic [9:0] addr);
        run_instr(0, 0, $urandom(), 1'b1, RK_JUMP, addr, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetN = 1'b0;
        set_idle();

        // Reset release, same-cycle ack of 0xA5.
        do_reset();
        cycle_idle();
        check_eq("t1_req",   32'(bus.imemReq),  32'd1);
        check_eq("t1_addr",  32'(bus.imemAddr), 32'd0);
        cycle(1'b1, 32'hA5, 1'b0, 1'b0, 2'b00, 10'd0, 1'b0, 1'b0);
        check_eq("t1_valid", 32'(bus.instrValid), 32'd1);
        check_eq("t1_instr", bus.instr,           32'hA5);
        check_eq("t1_ipc",   32'(bus.instrPc),    32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 2'b00, 10'd0, 1'b0, 1'b0);
        check_eq("t1_next",  32'(bus.imemAddr),   32'd1);

        // Slow memory and slow decode.
        run_instr(3, 4, 32'hDEAD_BEEF, 1'b0, 2'b00, 10'd0, 1'b0);
        check_eq("t2_addr", 32'(bus.imemAddr), 32'd2);

        // Relative branch backwards, absolute jump, wrap at the top.
        goto_pc(10'd5);
        run_instr(1, 1, $urandom(), 1'b1, RK_BRANCH, 10'h3FD, 1'b0);
        check_eq("t3_branch", 32'(bus.imemAddr), 32'd3);
        run_instr(0, 2, $urandom(), 1'b1, RK_JUMP, 10'h200, 1'b0);
        check_eq("t3_jump", 32'(bus.imemAddr), 32'h200);
        goto_pc(10'h3FF);
        run_instr(0, 0, $urandom(), 1'b0, 2'b00, 10'd0, 1'b0);
        check_eq("t4_wrap", 32'(bus.imemAddr), 32'h000);

        // Halt at instrPc 7, idle while halted despite noise, resume to 8.
        goto_pc(10'd7);
        run_instr(0, 1, $urandom(), 1'b0, 2'b00, 10'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_eq("t5_halted", 32'(bus.halted),  32'd1);
            check_eq("t5_noreq",  32'(bus.imemReq), 32'd0);
            cycle(1'b1, $urandom(), 1'b1, 1'b1, RK_JUMP, 10'h155, 1'b1, 1'b0);
        end
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 10'd0, 1'b0, 1'b1);
        check_eq("t5_resume", 32'(bus.imemReq),  32'd1);
        check_eq("t5_addr",   32'(bus.imemAddr), 32'd8);

        // Halt combined with a jump still lands on the target.
        run_instr(0, 0, $urandom(), 1'b1, RK_JUMP, 10'h055, 1'b1);
        check_eq("t6_halt_pc", 32'(bus.programCounter), 32'h055);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 10'd0, 1'b0, 1'b1);

        // Call and return, then return on an empty stack.
        goto_pc(10'd4);
        run_instr(0, 0, $urandom(), 1'b1, RK_CALL, 10'h100, 1'b0);
        check_eq("t7_call", 32'(bus.imemAddr), 32'h100);
        run_instr(0, 0, $urandom(), 1'b1, RK_RET, 10'h3C0, 1'b0);
`ifdef PC_RETURN_STACK_EN
        check_eq("t7_ret", 32'(bus.imemAddr), 32'd5);
`else
        check_eq("t7_ret", 32'(bus.imemAddr), 32'h101);
`endif
        goto_pc(10'd9);
        run_instr(0, 0, $urandom(), 1'b1, RK_RET, 10'h3C0, 1'b0);
        check_eq("t7_empty_ret", 32'(bus.imemAddr), 32'd10);
`ifdef PC_RETURN_STACK_EN
        check_eq("t7_fault", 32'(bus.stackFault), 32'd1);
`else
        check_eq("t7_fault", 32'(bus.stackFault), 32'd0);
`endif

        // Overflow: four calls fill the stack, the fifth still jumps but is not recorded.
        do_reset();
        cycle_idle();
        for (int k = 0; k < 4; k++)
            run_instr(0, 0, $urandom(), 1'b1, RK_CALL, 10'(16 * (k + 1)), 1'b0);
        check_eq("t8_fill_fault", 32'(bus.stackFault), 32'd0);
        run_instr(0, 0, $urandom(), 1'b1, RK_CALL, 10'h2A0, 1'b0);
        check_eq("t8_over_pc", 32'(bus.imemAddr), 32'h2A0);
        run_instr(0, 0, $urandom(), 1'b1, RK_RET, 10'd0, 1'b0);
`ifdef PC_RETURN_STACK_EN
        check_eq("t8_over_fault", 32'(bus.stackFault), 32'd1);
        check_eq("t8_ret_pc",     32'(bus.imemAddr),   32'h031);
`else
        check_eq("t8_over_fault", 32'(bus.stackFault), 32'd0);
        check_eq("t8_ret_pc",     32'(bus.imemAddr),   32'h2A1);
`endif

        // Random traffic, including stray acks, ignored redirects and occasional mid-flight resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 2) == 0), $urandom(), 1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 10'($urandom()),
                      1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
